// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared definitions for the control/status register bank: register map
// addresses, bit positions inside the typed registers, and the per-address
// register type used by the write decode.
// -----------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int unsigned ADDR_W = 4;

    // Register map
    localparam logic [ADDR_W-1:0] ADDR_CTRL      = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_STAT  = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK  = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_CFG0      = 4'd4;
    localparam logic [ADDR_W-1:0] ADDR_CFG1      = 4'd5;
    localparam logic [ADDR_W-1:0] ADDR_CFG2      = 4'd6;
    localparam logic [ADDR_W-1:0] ADDR_CFG3      = 4'd7;
    localparam logic [ADDR_W-1:0] ADDR_EVT_COUNT = 4'd8;
    localparam logic [ADDR_W-1:0] ADDR_VERSION   = 4'd15;

    // CTRL bit positions
    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_ENABLE  = 1;
    localparam int unsigned CTRL_CNT_CLR = 2;

    // STATUS bit positions
    localparam int unsigned STATUS_BUSY  = 0;
    localparam int unsigned STATUS_ERR   = 1;

    // IRQ_STAT / IRQ_MASK bit positions
    localparam int unsigned IRQ_DONE     = 0;
    localparam int unsigned IRQ_ERR      = 1;

    // SC covers CTRL: its strobe bits self-clear, ENABLE is stored alongside.
    typedef enum logic [1:0] {RW, RO, W1C, SC} reg_type_t;

    function automatic reg_type_t reg_type_of(input logic [ADDR_W-1:0] addr);
        case (addr)
            ADDR_CTRL:                                 return SC;
            ADDR_STATUS, ADDR_EVT_COUNT, ADDR_VERSION: return RO;
            ADDR_IRQ_STAT:                             return W1C;
            default:                                   return RW;
        endcase
    endfunction

endpackage

// File: rtl/reg_bank_ctrl_event_counter.sv
// -----------------------------------------------------------------------------
// event_counter
// Free-running wrap-around event counter.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count one event this cycle
//   clr        : clear to zero; wins over inc in the same cycle
//   count      : current count
// -----------------------------------------------------------------------------
module event_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// -----------------------------------------------------------------------------
// reg_bank_ctrl
// Control/status register bank behind the AXI-lite slave register channel.
// Sixteen 32-bit registers (RW, RO, W1C, self-clearing), an event counter
// and a masked, registered interrupt.
//   clk, reset             : clock, asynchronous active-high reset
//   write_addr/data/en     : one write per cycle with write_en high
//   read_addr, read_data   : zero-latency combinational read port
//   start_pulse            : one-cycle strobe per START write
//   core_enable            : CTRL.ENABLE
//   cfg_out                : {CFG3, CFG2, CFG1, CFG0}
//   core_busy/done/error   : core status inputs
//   irq                    : registered |(IRQ_STAT & IRQ_MASK)
// -----------------------------------------------------------------------------
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int unsigned                NUM_REGS   = 16,
    parameter int unsigned                DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]      VERSION    = 32'h0001_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       write_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    write_en,
    input  logic [ADDR_W-1:0]       read_addr,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    start_pulse,
    output logic                    core_enable,
    output logic [4*DATA_WIDTH-1:0] cfg_out,
    input  logic                    core_busy,
    input  logic                    core_done,
    input  logic                    core_error,
    output logic                    irq
);

    logic                  enable_q;
    logic [1:0]            status_q;
    logic                  err_prev_q;
    logic [1:0]            irq_stat_q;
    logic [1:0]            irq_mask_q;
    logic [DATA_WIDTH-1:0] rw_file [NUM_REGS];
    logic [DATA_WIDTH-1:0] evt_count;

    reg_type_t             wr_type;
    logic                  wr_ctrl;
    logic                  wr_w1c;
    logic                  wr_rw;
    logic                  cnt_clr;
    logic [1:0]            irq_set;

    // Write decode
    always_comb begin
        wr_type = reg_type_of(write_addr);
        wr_ctrl = write_en && (wr_type == SC);
        wr_w1c  = write_en && (wr_type == W1C);
        wr_rw   = write_en && (wr_type == RW);
    end

    // CNT_CLR acts in the write cycle itself so it overrides a same-cycle done.
    assign cnt_clr = wr_ctrl && write_data[CTRL_CNT_CLR];

    // The STATUS flop is the current error sample; err_prev_q holds the one
    // before it, so the ERR edge lands one cycle after STATUS shows the rise.
    always_comb begin
        irq_set           = '0;
        irq_set[IRQ_DONE] = core_done;
        irq_set[IRQ_ERR]  = status_q[STATUS_ERR] && !err_prev_q;
    end

    // CTRL: START is a pure strobe; back-to-back writes give back-to-back pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_pulse <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            start_pulse <= wr_ctrl && write_data[CTRL_START];
            if (wr_ctrl) begin
                enable_q <= write_data[CTRL_ENABLE];
            end
        end
    end

    // STATUS, IRQ_STAT, IRQ_MASK and the interrupt register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q   <= '0;
            err_prev_q <= 1'b0;
            irq_stat_q <= '0;
            irq_mask_q <= '0;
            irq        <= 1'b0;
        end else begin
            status_q[STATUS_BUSY] <= core_busy;
            status_q[STATUS_ERR]  <= core_error;
            err_prev_q            <= status_q[STATUS_ERR];
            // Hardware set is OR-ed after the clear, so set wins a collision.
            irq_stat_q <= (wr_w1c ? (irq_stat_q & ~write_data[1:0]) : irq_stat_q)
                          | irq_set;
            if (wr_rw && (write_addr == ADDR_IRQ_MASK)) begin
                irq_mask_q <= write_data[1:0];
            end
            irq <= |(irq_stat_q & irq_mask_q);
        end
    end

    // CFG and SCRATCH storage, indexed by address; slots for other addresses
    // are never written and stay at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this array is a bank of flops, not a RAM macro, so it
            // takes the asynchronous reset like any other register.
            for (int i = 0; i < NUM_REGS; i++) begin
                rw_file[i] <= '0;
            end
        end else if (wr_rw && (write_addr != ADDR_IRQ_MASK)) begin
            rw_file[write_addr] <= write_data;
        end
    end

    event_counter #(
        .WIDTH (DATA_WIDTH)
    ) u_evt_count (
        .clk   (clk),
        .reset (reset),
        .inc   (core_done),
        .clr   (cnt_clr),
        .count (evt_count)
    );

    assign core_enable = enable_q;
    assign cfg_out     = {rw_file[ADDR_CFG3], rw_file[ADDR_CFG2],
                          rw_file[ADDR_CFG1], rw_file[ADDR_CFG0]};

    // Read mux
    always_comb begin
        // NOTE: default first so every path assigns read_data; no latch.
        read_data = '0;
        case (read_addr)
            ADDR_CTRL:      read_data[CTRL_ENABLE] = enable_q;
            ADDR_STATUS:    read_data[1:0]         = status_q;
            ADDR_IRQ_STAT:  read_data[1:0]         = irq_stat_q;
            ADDR_IRQ_MASK:  read_data[1:0]         = irq_mask_q;
            ADDR_EVT_COUNT: read_data              = evt_count;
            ADDR_VERSION:   read_data              = VERSION;
            default:        read_data              = rw_file[read_addr];
        endcase
    end

endmodule
